pdm_mic_capture: RTL and testbench
==================================

// Module: pdm_mic_capture
// PURPOSE
//   Parametrised PDM microphone front end. Generates the mic bit clock (mclk) from clk and
//   samples the 1-bit PDM stream (dataint). Decimates by popcount over DECIM mic periods
//   (boxcar / CIC-1) and delivers left-justified PCM words on a valid/ready interface.
//   Sits between the board mic pins and the audio buffer / PCM playback path.
// PARAMETERS
//   CLK_DIV  2    clk cycles per mclk half-period (>=1); mclk = clk/(2*CLK_DIV)
//   DECIM    64   PDM bits per PCM sample per channel (>=2)
//   PCM_W    16   PCM output width; must be >= CNT_W = $clog2(DECIM+1)
//   WARM     16   mclk periods discarded after enable rises (mic start-up)
// PORTS
//   clk        in   1      system clock, rising-edge
//   reset      in   1      asynchronous, active-high
//   enable     in   1      1 = run capture; 0 = stop, return to IDLE
//   dataint    in   1      PDM data from microphone
//   mclk       out  1      mic bit clock
//   pcm_data   out  PCM_W  PCM sample, popcount << (PCM_W-CNT_W)
//   pcm_ch     out  1      channel of pcm_data (0 = left; 1 = right, stereo build only)
//   pcm_valid  out  1      pcm_data/pcm_ch hold a sample
//   pcm_ready  in   1      consumer accepts the sample when pcm_valid & pcm_ready
//   overrun    out  1      sticky: a sample completed while the previous one was unaccepted
// BEHAVIOUR
//   Reset: mclk=0, pcm_data=0, pcm_ch=0, pcm_valid=0, overrun=0, all counters 0, state IDLE.
//   Reset mid-window aborts the window; partial counts are discarded.
//   dataint passes through one input flop (din_q). All captures use din_q.
//   Divider: div_cnt counts 0..CLK_DIV-1 in WARMUP/RUN; at CLK_DIV-1 it wraps and mclk toggles.
//   Capture events: C0 = cycle mclk is driven 1->0; C1 = cycle mclk is driven 0->1.
//   FSM:
//     IDLE   : mclk held 0, counters cleared. enable=1 -> WARMUP.
//     WARMUP : mclk runs, captures ignored. After WARM C0 events -> RUN, window count cleared.
//     RUN    : on C0, ones0 += din_q and bit_cnt++. At the DECIM-th C0:
//              - load pcm_data = (ones0 + din_q) << (PCM_W-CNT_W), pcm_ch = 0;
//              - assert pcm_valid on the next clk;
//              - clear ones0 and bit_cnt.
//              Latency: 1 clk after the last capture.
//     Any state: enable=0 -> IDLE on the next clk. pcm_valid, pcm_data and overrun clear;
//              any pending sample is dropped.
//   Count width: popcount range 0..DECIM in CNT_W bits; no saturation is needed.
//     All-ones input gives DECIM << (PCM_W-CNT_W).
//   Handshake: pcm_valid stays high until a cycle with pcm_ready=1, then drops the next clk.
//     pcm_data is stable while pcm_valid=1 and pcm_ready=0, unless a new sample completes.
//   New sample with pcm_valid=1 and pcm_ready=0: the new sample overwrites, pcm_valid stays 1,
//     overrun sets. overrun clears only on reset or enable=0.
//   New sample in the same cycle as an accept: the new sample loads, pcm_valid stays 1,
//     no overrun.
// CONFIGURATION
//   PDM_STEREO_EN defined: C1 events also capture into ones1 (right channel, own bit count).
//     Two completions are presented in order L then R via a 1-deep R holding register.
//     R presents on the cycle after L is accepted.
//     Overrun is set if either channel is overwritten.
//   PDM_STEREO_EN undefined: C1 captures nothing, pcm_ch is tied 0, there is no R logic.
// STRUCTURE
//   Shared package pdm_pkg:
//     - state encoding typedef (IDLE, WARMUP, RUN);
//     - function clog2_cnt(DECIM);
//     - constant PCM_CH_L=0 / PCM_CH_R=1.
//   Sub-module pdm_clkgen (divider, mclk, C0/C1 strobes). The accumulators, FSM and
//   handshake stay in the top level.
// TESTING  (CLK_DIV=2, DECIM=8, PCM_W=16, WARM=2, so CNT_W=4 and shift=12)
//   1. enable=1, dataint=1 constant, pcm_ready=1
//      -> first pcm_valid after 2+8 mclk periods, pcm_data=16'h8000, mclk period 4 clk.
//   2. dataint alternating 1,0 per mclk period
//      -> pcm_data=16'h4000; dataint=0 constant -> 16'h0000.
//   3. pcm_ready=0 across two completed windows
//      -> overrun=1, pcm_data = second window's value, pcm_valid=1. Then pcm_ready=1 for 1 clk
//      -> pcm_valid=0 on the next clk.
//   4. reset pulse mid-window (after 3 captures)
//      -> all outputs 0 immediately, mclk=0. Release reset with enable=1
//      -> WARMUP restarts and the first sample is a full fresh window.
//   5. enable=0 while pcm_valid=1 and overrun=1
//      -> the next clk gives pcm_valid=0, overrun=0, mclk held 0.
//   6. PDM_STEREO_EN, dataint=1 on C0 and 0 on C1
//      -> samples alternate ch0=16'h8000, ch1=16'h0000, in order L then R.

Source files
------------

// File: rtl/pdm_pkg.sv
// Shared definitions for the PDM microphone capture block.
package pdm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } pdm_state_t;

  localparam logic PCM_CH_L = 1'b0;
  localparam logic PCM_CH_R = 1'b1;

  // Bits needed to hold a popcount in the range 0..decim.
  function automatic int clog2_cnt(input int decim);
    return $clog2(decim + 1);
  endfunction

endpackage

// File: rtl/pdm_mic_capture_clkgen.sv
// Mic bit-clock divider: mclk = clk/(2*CLK_DIV) while i_run is high, held 0 otherwise.
// o_c0 / o_c1 strobe in the cycle whose closing edge drives mclk 1->0 / 0->1.
module pdm_clkgen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_run,
  output logic o_mclk,
  output logic o_c0,
  output logic o_c1
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] r_div_cnt;
  logic          r_mclk;
  logic          w_wrap;

  assign w_wrap = (r_div_cnt == DW'(CLK_DIV - 1));
  assign o_mclk = r_mclk;
  assign o_c0   = i_run & w_wrap & r_mclk;
  assign o_c1   = i_run & w_wrap & ~r_mclk;

  // Divider counter and mclk toggle; stopping the divider parks mclk low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_cnt <= '0;
      r_mclk    <= 1'b0;
    end else if (!i_run) begin
      r_div_cnt <= '0;
      r_mclk    <= 1'b0;
    end else if (w_wrap) begin
      r_div_cnt <= '0;
      r_mclk    <= ~r_mclk;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pdm_mic_capture.sv
// PDM microphone front end: mclk generation, boxcar decimation by popcount,
// left-justified PCM on a valid/ready interface with sticky overrun.
// Optional build macro PDM_STEREO_EN adds the right channel captured on mclk rising.
//
// state  | meaning
// IDLE   | mclk parked low, counters cleared, waiting for enable
// WARMUP | mclk running, captures discarded for WARM mic periods
// RUN    | capturing windows of DECIM bits and emitting PCM samples
module pdm_mic_capture
  import pdm_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int DECIM   = 64,
  parameter int PCM_W   = 16,
  parameter int WARM    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             dataint,
  output logic             mclk,
  output logic [PCM_W-1:0] pcm_data,
  output logic             pcm_ch,
  output logic             pcm_valid,
  input  logic             pcm_ready,
  output logic             overrun
);

  localparam int CNT_W = clog2_cnt(DECIM);
  localparam int SHIFT = PCM_W - CNT_W;
  localparam int WRM_W = (WARM > 1) ? $clog2(WARM) : 1;

  pdm_state_t       r_state, w_next;
  logic             r_din_q;
  logic [WRM_W-1:0] r_warm_cnt;
  logic [CNT_W-1:0] r_ones0, r_bit_cnt0;
  logic [PCM_W-1:0] r_pcm_data;
  logic             r_pcm_valid, r_overrun;
  logic             w_run, w_c0, w_c1;
  logic             w_accept, w_last0, w_comp0;
  logic [CNT_W-1:0] w_sum0;
  logic [PCM_W-1:0] w_pcm0;

  assign w_run    = enable && (r_state != ST_IDLE);
  assign w_accept = r_pcm_valid && pcm_ready;
  assign w_last0  = (r_bit_cnt0 == CNT_W'(DECIM - 1));
  assign w_comp0  = (r_state == ST_RUN) && w_c0 && w_last0;
  // The completing bit is added here so the window closes on its last capture.
  assign w_sum0   = r_ones0 + CNT_W'(r_din_q);
  assign w_pcm0   = PCM_W'(w_sum0) << SHIFT;

  assign pcm_data  = r_pcm_data;
  assign pcm_valid = r_pcm_valid;
  assign overrun   = r_overrun;

  pdm_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk    (clk),
    .reset  (reset),
    .i_run  (w_run),
    .o_mclk (mclk),
    .o_c0   (w_c0),
    .o_c1   (w_c1)
  );

  // Single input flop on the mic data line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_din_q <= 1'b0;
    else       r_din_q <= dataint;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; dropping enable wins from any state.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (enable) w_next = ST_WARMUP;
      ST_WARMUP: if (w_c0 && (r_warm_cnt == WRM_W'(WARM - 1))) w_next = ST_RUN;
      ST_RUN:    w_next = ST_RUN;
      default:   w_next = ST_IDLE;
    endcase
    if (!enable) w_next = ST_IDLE;
  end

`ifdef PDM_STEREO_EN
  logic [CNT_W-1:0] r_ones1, r_bit_cnt1;
  logic [PCM_W-1:0] r_hold_data;
  logic             r_hold_vld, r_pcm_ch;
  logic             w_comp1, w_hold_move;
  logic [CNT_W-1:0] w_sum1;
  logic [PCM_W-1:0] w_pcm1;

  assign w_comp1     = (r_state == ST_RUN) && w_c1 && (r_bit_cnt1 == CNT_W'(DECIM - 1));
  assign w_sum1      = r_ones1 + CNT_W'(r_din_q);
  assign w_pcm1      = PCM_W'(w_sum1) << SHIFT;
  // Right sample leaves the holding register once the output slot is free
  // and no left sample is claiming it in the same cycle.
  assign w_hold_move = r_hold_vld && !w_comp0 && (!r_pcm_valid || w_accept);
  assign pcm_ch      = r_pcm_ch;

  // Right-channel holding register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold_data <= '0;
      r_hold_vld  <= 1'b0;
    end else if (!enable) begin
      r_hold_data <= '0;
      r_hold_vld  <= 1'b0;
    end else if (w_comp1) begin
      r_hold_data <= w_pcm1;
      r_hold_vld  <= 1'b1;
    end else if (w_hold_move) begin
      r_hold_vld  <= 1'b0;
    end
  end
`else
  logic w_unused_c1;
  assign w_unused_c1 = w_c1;
  assign pcm_ch      = PCM_CH_L;
`endif

  // Warm-up and window counters; everything clears outside the active states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_warm_cnt <= '0;
      r_ones0    <= '0;
      r_bit_cnt0 <= '0;
`ifdef PDM_STEREO_EN
      r_ones1    <= '0;
      r_bit_cnt1 <= '0;
`endif
    end else if (!enable || (r_state == ST_IDLE)) begin
      r_warm_cnt <= '0;
      r_ones0    <= '0;
      r_bit_cnt0 <= '0;
`ifdef PDM_STEREO_EN
      r_ones1    <= '0;
      r_bit_cnt1 <= '0;
`endif
    end else begin
      if ((r_state == ST_WARMUP) && w_c0) r_warm_cnt <= r_warm_cnt + 1'b1;
      if ((r_state == ST_RUN) && w_c0) begin
        if (w_last0) begin
          r_ones0    <= '0;
          r_bit_cnt0 <= '0;
        end else begin
          r_ones0    <= w_sum0;
          r_bit_cnt0 <= r_bit_cnt0 + 1'b1;
        end
      end
`ifdef PDM_STEREO_EN
      if ((r_state == ST_RUN) && w_c1) begin
        if (w_comp1) begin
          r_ones1    <= '0;
          r_bit_cnt1 <= '0;
        end else begin
          r_ones1    <= w_sum1;
          r_bit_cnt1 <= r_bit_cnt1 + 1'b1;
        end
      end
`endif
    end
  end

  // Output sample register, valid/ready handshake and sticky overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pcm_data  <= '0;
      r_pcm_valid <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef PDM_STEREO_EN
      r_pcm_ch    <= PCM_CH_L;
`endif
    end else if (!enable) begin
      r_pcm_data  <= '0;
      r_pcm_valid <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef PDM_STEREO_EN
      r_pcm_ch    <= PCM_CH_L;
`endif
    end else begin
      if (w_comp0) begin
        r_pcm_data  <= w_pcm0;
        r_pcm_valid <= 1'b1;
        if (r_pcm_valid && !pcm_ready) r_overrun <= 1'b1;
`ifdef PDM_STEREO_EN
        r_pcm_ch    <= PCM_CH_L;
      end else if (w_hold_move) begin
        r_pcm_data  <= r_hold_data;
        r_pcm_valid <= 1'b1;
        r_pcm_ch    <= PCM_CH_R;
`endif
      end else if (w_accept) begin
        r_pcm_valid <= 1'b0;
      end
`ifdef PDM_STEREO_EN
      if (w_comp1 && r_hold_vld && !w_hold_move) r_overrun <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_pdm_mic_capture.sv
// Bench for pdm_mic_capture (CLK_DIV=2, DECIM=8, PCM_W=16, WARM=2).
module tb_pdm_mic_capture;

  localparam int CLK_DIV = 2;
  localparam int DECIM   = 8;
  localparam int PCM_W   = 16;
  localparam int WARM    = 2;
  localparam int SHIFT   = 12;
  localparam int PER     = 2 * CLK_DIV;

  logic             clk = 1'b0;
  logic             reset, enable, dataint, pcm_ready;
  logic             mclk, pcm_ch, pcm_valid, overrun;
  logic [PCM_W-1:0] pcm_data;

  int n_checks = 0;
  int n_fail   = 0;

  pdm_mic_capture #(.CLK_DIV(CLK_DIV), .DECIM(DECIM), .PCM_W(PCM_W), .WARM(WARM)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .dataint   (dataint),
    .mclk      (mclk),
    .pcm_data  (pcm_data),
    .pcm_ch    (pcm_ch),
    .pcm_valid (pcm_valid),
    .pcm_ready (pcm_ready),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: time measured in clk cycles since the run began (m_k);
  // mic periods are PER cycles, falling mclk closes each period.
  bit        m_act = 0, m_dq = 0;
  int        m_k = 0, m_o0 = 0, m_b0 = 0, m_ncomp = 0;
  bit        e_valid = 0, e_ovr = 0, e_ch = 0;
  logic [15:0] e_data = '0;
  int        m_o1 = 0, m_b1 = 0;
  bit        h_v = 0;
  logic [15:0] h_d = '0;

  task automatic m_clear();
    m_act = 0; m_k = 0; m_o0 = 0; m_b0 = 0; m_o1 = 0; m_b1 = 0;
    e_valid = 0; e_ovr = 0; e_ch = 0; e_data = '0; h_v = 0; h_d = '0;
  endtask

  always @(posedge clk) begin
    bit acc, comp0, comp1, move;
    int v0, v1;
    comp0 = 0; comp1 = 0; v0 = 0; v1 = 0;
    if (reset) begin
      m_clear();
      m_dq = 0;
    end else begin
      acc = e_valid && pcm_ready;
      if (!enable) m_clear();
      else if (!m_act) begin
        m_act = 1; m_k = 0;
      end else begin
        if (m_k >= WARM * PER && (m_k % PER) == PER - 1) begin
          m_o0 += m_dq; m_b0++;
          if (m_b0 == DECIM) begin comp0 = 1; v0 = m_o0; m_o0 = 0; m_b0 = 0; end
        end
`ifdef PDM_STEREO_EN
        if (m_k >= WARM * PER && (m_k % PER) == CLK_DIV - 1) begin
          m_o1 += m_dq; m_b1++;
          if (m_b1 == DECIM) begin comp1 = 1; v1 = m_o1; m_o1 = 0; m_b1 = 0; end
        end
`endif
        move = h_v && !comp0 && (!e_valid || acc);
        if (comp1 && h_v && !move) e_ovr = 1;
        if (comp0) begin
          if (e_valid && !pcm_ready) e_ovr = 1;
          e_data = 16'(v0 << SHIFT); e_ch = 0; e_valid = 1; m_ncomp++;
        end else if (move) begin
          e_data = h_d; e_ch = 1; e_valid = 1; h_v = 0;
        end else if (acc) e_valid = 0;
        if (comp1) begin h_d = 16'(v1 << SHIFT); h_v = 1; end
        m_k++;
      end
      m_dq = dataint;
    end
  end

  // Every-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    chk("cyc_valid", 32'(pcm_valid), 32'(e_valid));
    chk("cyc_data", 32'(pcm_data), 32'(e_data));
    chk("cyc_overrun", 32'(overrun), 32'(e_ovr));
    chk("cyc_ch", 32'(pcm_ch), 32'(e_ch));
    chk("cyc_mclk", 32'(mclk), m_act ? 32'((m_k / CLK_DIV) % 2) : 32'd0);
  end

  task automatic wait_comp(input int n);
    int target;
    target = m_ncomp + n;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (m_ncomp >= target) return;
    end
    n_checks++; n_fail++;
    $display("FAIL wait_comp timeout actual=%0d required=%0d", m_ncomp, target);
  endtask

  // Counts posedges from now until pcm_valid is seen; records mclk rise times.
  task automatic first_valid(output int at, output int rise1, output int rise2);
    bit prev;
    prev = 0; at = -1; rise1 = -1; rise2 = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (mclk && !prev) begin
        if (rise1 < 0) rise1 = i; else if (rise2 < 0) rise2 = i;
      end
      prev = mclk;
      if (pcm_valid) begin at = i; return; end
    end
  endtask

  initial begin
    int at, r1, r2, nseen;
    logic [15:0] last;
    reset = 1; enable = 0; dataint = 0; pcm_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(pcm_valid), 0);
    chk("rst_mclk", 32'(mclk), 0);
    chk("rst_data", 32'(pcm_data), 0);
    chk("rst_overrun", 32'(overrun), 0);
    @(negedge clk); reset = 0;
    repeat (3) @(negedge clk);

    // 1: constant ones
    dataint = 1; enable = 1;
    first_valid(at, r1, r2);
    chk("t1_first_valid_cycle", 32'(at), 41);
    chk("t1_mclk_first_rise", 32'(r1), 3);
    chk("t1_mclk_period", 32'(r2 - r1), 4);
    chk("t1_data", 32'(pcm_data), 32'h8000);

    // 2: alternating per mic period, then constant zero
    last = 16'hffff; nseen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i % PER == 0) dataint = ~dataint;
      if (pcm_valid) begin last = pcm_data; nseen++; end
    end
    chk("t2_alt_seen", 32'(nseen > 1), 1);
    chk("t2_alt_data", 32'(last), 32'h4000);
    last = 16'hffff; nseen = 0;
    dataint = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pcm_valid) begin last = pcm_data; nseen++; end
    end
    chk("t2_zero_seen", 32'(nseen > 1), 1);
    chk("t2_zero_data", 32'(last), 32'h0000);

    // 3: back-pressure across two windows
    pcm_ready = 0;
    wait_comp(1);
    chk("t3_first_no_overrun", 32'(overrun), 0);
    @(negedge clk); dataint = 1;
    wait_comp(1);
    chk("t3_valid", 32'(pcm_valid), 1);
    chk("t3_overrun", 32'(overrun), 1);
    chk("t3_data", 32'(pcm_data), 32'h8000);
    @(negedge clk); pcm_ready = 1;
    @(posedge clk); #1;
    chk("t3_valid_drop", 32'(pcm_valid), 0);
    chk("t3_overrun_sticky", 32'(overrun), 1);

    // 4: reset after three ones-captures; fresh window must be all zero
    wait_comp(1);
    repeat (12) @(posedge clk);
    @(negedge clk); reset = 1; dataint = 0;
    #1;
    chk("t4_rst_valid", 32'(pcm_valid), 0);
    chk("t4_rst_data", 32'(pcm_data), 0);
    chk("t4_rst_overrun", 32'(overrun), 0);
    chk("t4_rst_mclk", 32'(mclk), 0);
    repeat (3) @(negedge clk);
    reset = 0;
    first_valid(at, r1, r2);
    chk("t4_first_valid_cycle", 32'(at), 41);
    chk("t4_fresh_data", 32'(pcm_data), 32'h0000);

    // 5: disable while a sample is pending with overrun set
    @(negedge clk); pcm_ready = 0; dataint = 1;
    wait_comp(2);
    chk("t5_pre_overrun", 32'(overrun), 1);
    chk("t5_pre_valid", 32'(pcm_valid), 1);
    @(negedge clk); enable = 0;
    @(posedge clk); #1;
    chk("t5_valid", 32'(pcm_valid), 0);
    chk("t5_overrun", 32'(overrun), 0);
    chk("t5_data", 32'(pcm_data), 0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("t5_mclk_held", 32'(mclk), 0);
    end

`ifdef PDM_STEREO_EN
    // 6: data high on falling mclk captures, low on rising
    begin
      logic [15:0] sd[4];
      logic        sc[4];
      int          ns;
      ns = 0;
      @(negedge clk); pcm_ready = 1; dataint = 0; enable = 1;
      for (int i = 0; i < 140; i++) begin
        @(negedge clk);
        if (pcm_valid && pcm_ready && ns < 4) begin sd[ns] = pcm_data; sc[ns] = pcm_ch; ns++; end
        dataint = mclk;
      end
      chk("t6_count", 32'(ns), 4);
      for (int j = 0; j < ns; j++) begin
        chk("t6_ch", 32'(sc[j]), 32'(j % 2));
        chk("t6_data", 32'(sd[j]), (j % 2 == 0) ? 32'h8000 : 32'h0000);
      end
    end
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
